// File: rtl/vertex_dma.sv
`default_nettype none
// ============================================================================
// Module   : vertex_dma
// Purpose  : Vertex-port DMA initiator. It fetches a block from data memory
//            onto a stream, or stores a block from a stream into memory.
// Revision : 1.0 - initial release
// ============================================================================
module vertex_dma #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data
);

    localparam logic [ADDR_W:0] c_one = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_STORE = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_issued;
    logic [ADDR_W:0]   r_popped;
    logic [ADDR_W:0]   r_written;
    logic              r_pending;
    logic              r_done;
    logic [DATA_W-1:0] r_fifo [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_fifo_cnt;

    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic              w_store_hs;
    logic [ADDR_W-1:0] w_mem_addr;

    assign w_pop      = out_valid & out_ready;
    assign w_push     = r_pending;
    // Occupancy after this cycle's push/pop; a new read needs a free slot beyond it.
    assign w_occ      = {1'b0, r_fifo_cnt} + {2'b00, r_pending} - {2'b00, w_pop};
    assign w_issue    = (r_state == S_FETCH) && (r_issued < r_count) && (w_occ < 3'd2);
    assign w_store_hs = (r_state == S_STORE) && in_valid;

    always_comb begin
        w_mem_addr = r_addr;
        if (r_state == S_STORE) begin
            w_mem_addr = r_base + r_written[ADDR_W-1:0];
        end else if (w_issue) begin
            w_mem_addr = r_base + r_issued[ADDR_W-1:0];
        end
    end

    assign mem_addr  = w_mem_addr;
    assign mem_we    = w_store_hs;
    assign mem_wdata = w_store_hs ? in_data : '0;
    assign in_ready  = (r_state == S_STORE);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign out_valid = (r_fifo_cnt != 2'd0);
    assign out_data  = r_fifo[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_issued   <= '0;
            r_popped   <= '0;
            r_written  <= '0;
            r_pending  <= 1'b0;
            r_done     <= 1'b0;
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            r_done     <= 1'b0;
            r_addr     <= w_mem_addr;
            r_pending  <= w_issue;
            r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push) begin
                r_fifo[r_wr_ptr] <= mem_rdata;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_popped <= r_popped + c_one;
            end
            if (w_issue) begin
                r_issued <= r_issued + c_one;
            end
            if (w_store_hs) begin
                r_written <= r_written + c_one;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base    <= base;
                        r_count   <= count;
                        r_issued  <= '0;
                        r_popped  <= '0;
                        r_written <= '0;
                        if (count == '0) begin
                            r_done <= 1'b1;
                        end else if (op) begin
                            r_state <= S_STORE;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_issue && (r_issued + c_one == r_count)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && (r_popped + c_one == r_count)) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                S_STORE: begin
                    if (w_store_hs && (r_written + c_one == r_count)) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vertex_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_vertex_dma
// Purpose  : Scoreboard bench for vertex_dma against a memory/queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vertex_dma;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [7:0]   base;
    logic [8:0]   count;
    logic         busy;
    logic         done;
    logic [7:0]   mem_addr;
    logic         mem_we;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;

    vertex_dma #(.ADDR_W(8), .DATA_W(128)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .base(base), .count(count),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
    );

    always #5 clk = ~clk;

    // Data memory with one-cycle registered read
    logic [127:0] tb_mem [0:255];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr];
    end

    logic [127:0] ref_mem [0:255];
    logic [127:0] exp_out[$];
    logic [7:0]   exp_wa[$];
    logic [127:0] exp_wd[$];
    logic [127:0] in_q[$];
    int           exp_done = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    int           done_cyc;
    logic [7:0]   addr_hist [0:1023];
    logic         we_hist [0:1023];
    logic         valid_hist [0:1023];
    logic         busy_hist [0:1023];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pops expectations whenever the DUT presents an output event
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    n_checks++;
                    $display("FAIL out_unexpected: got %0h expected none", out_data);
                end else chk("out_data", out_data, exp_out.pop_front());
            end
            if (mem_we) begin
                if (exp_wa.size() == 0) begin
                    n_checks++;
                    $display("FAIL wr_unexpected: got addr %0h expected none", mem_addr);
                end else begin
                    chk("wr_addr", mem_addr, exp_wa.pop_front());
                    chk("wr_data", mem_wdata, exp_wd.pop_front());
                end
            end
            if (done) begin
                if (exp_done == 0) begin
                    n_checks++;
                    $display("FAIL done_unexpected: got 1 expected 0");
                end else begin
                    exp_done--;
                    chk("done_busy", busy, 1'b0);
                end
            end
        end
    end

    task automatic go_set(input bit o, input logic [7:0] b, input logic [8:0] c);
        logic [127:0] d;
        logic [7:0]   a;
        start = 1'b1; op = o; base = b; count = c;
        exp_done++;
        for (int i = 0; i < int'(c); i++) begin
            a = b + 8'(i);
            if (o) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                in_q.push_back(d);
                exp_wa.push_back(a);
                exp_wd.push_back(d);
                ref_mem[a] = d;
            end else begin
                exp_out.push_back(ref_mem[a]);
            end
        end
    endtask

    task automatic go_end();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode: 0 full rate, 1 random gaps, 2 out_ready low in cycles 3..9,
    //       3 extra start in cycle 2, 4 stop after two out beats
    task automatic run(input int budget, input int mode);
        int  hs;
        bit  stop;
        hs = 0; stop = 0; done_cyc = -1;
        for (int cy = 1; cy <= budget; cy++) begin
            out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0)
                      : (mode == 2) ? !(cy >= 3 && cy <= 9) : 1'b1;
            if (in_q.size() > 0 && (mode != 1 || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1; in_data = in_q[0];
            end else begin
                in_valid = 1'b0; in_data = '0;
            end
            if (mode == 3) begin
                start = (cy == 2);
                if (cy == 2) begin op = 1'b1; count = 9'd5; end
            end
            @(negedge clk);
            if (cy < 1024) begin
                addr_hist[cy] = mem_addr; we_hist[cy] = mem_we;
                valid_hist[cy] = out_valid; busy_hist[cy] = busy;
            end
            if (in_valid && in_ready) void'(in_q.pop_front());
            if (out_valid && out_ready) hs++;
            if (done) begin done_cyc = cy; stop = 1; break; end
            if (mode == 4 && hs == 2) begin stop = 1; break; end
            @(posedge clk); #1;
        end
        chk("run_timeout", stop, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1; start = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_mem_we"}, mem_we, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 8'h00);
        chk({tag, "_mem_wdata"}, mem_wdata, 128'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        rst = 1'b1; start = 1'b0; op = 1'b0; base = '0; count = '0;
        out_ready = 1'b1; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        reset_checks("reset");
        @(posedge clk); #1;

        // Fill all memory (count=256 wraps exactly once)
        go_set(1'b1, 8'($urandom), 9'd256); go_end(); run(600, 0);
        chk("store256_done_cycle", done_cyc, 257);

        go_set(1'b1, 8'h10, 9'd4); go_end(); run(50, 0);
        for (int c = 1; c <= 4; c++) chk("store4_we", we_hist[c], 1'b1);
        chk("store4_done_cycle", done_cyc, 5);
        chk("store4_busy_at_done", busy_hist[5], 1'b0);

        go_set(1'b0, 8'h10, 9'd4); go_end(); run(50, 0);
        chk("fetch4_first_addr", addr_hist[1], 8'h10);
        chk("fetch4_valid_c2", valid_hist[2], 1'b0);
        for (int c = 3; c <= 6; c++) chk("fetch4_valid_run", valid_hist[c], 1'b1);
        chk("fetch4_done_cycle", done_cyc, 7);

        go_set(1'b0, 8'h40, 9'd8); go_end(); run(100, 2);
        chk("bp_addr_held_c3", addr_hist[3], 8'h41);
        chk("bp_addr_held_c9", addr_hist[9], 8'h41);
        chk("bp_valid_c9", valid_hist[9], 1'b1);

        go_set(1'b0, 8'hFE, 9'd4); go_end(); run(50, 0);
        for (int i = 0; i < 4; i++) begin
            b = 8'hFE + 8'(i);
            chk("wrap_addr", addr_hist[i + 1], b);
        end

        go_set(1'b0, 8'h20, 9'd0); go_end(); run(10, 0);
        chk("cnt0_done_cycle", done_cyc, 1);
        chk("cnt0_busy", busy_hist[1], 1'b0);
        chk("cnt0_no_out", valid_hist[1], 1'b0);

        go_set(1'b0, 8'h30, 9'd3); go_end(); run(50, 3);
        chk("busy_start_done_cycle", done_cyc, 6);
        repeat (10) begin @(posedge clk); #1; end
        chk("busy_start_idle", busy, 1'b0);
        chk("busy_start_no_extra", exp_out.size(), 0);

        for (int k = 0; k < 6; k++) begin
            go_set(1'b1, 8'($urandom), 9'($urandom_range(1, 24))); go_end(); run(200, 1);
            go_set(1'b0, 8'($urandom), 9'($urandom_range(1, 24))); go_end(); run(200, 1);
        end

        go_set(1'b0, 8'($urandom), 9'd256); go_end(); run(600, 0);
        chk("fetch256_done_cycle", done_cyc, 259);

        // Abort a fetch mid-flight, then start again right after reset
        go_set(1'b0, 8'h50, 9'd6); go_end(); run(50, 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_out.delete();
        exp_done = 0;
        go_set(1'b0, 8'h60, 9'd2);
        @(negedge clk);
        reset_checks("abort");
        go_end(); run(50, 0);
        chk("post_abort_done_cycle", done_cyc, 5);

        repeat (5) begin @(posedge clk); #1; end
        chk("end_out_queue", exp_out.size(), 0);
        chk("end_wr_queue", exp_wa.size(), 0);
        chk("end_done_count", exp_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
